// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic RV32I instruction requests into 32-bit words
// and writes them into instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cls,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    input  logic              im_ack,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic              wrapped
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

    // Request classes
    localparam logic [3:0] CLS_ADD  = 4'd0;
    localparam logic [3:0] CLS_SUB  = 4'd1;
    localparam logic [3:0] CLS_OR   = 4'd2;
    localparam logic [3:0] CLS_AND  = 4'd3;
    localparam logic [3:0] CLS_ADDI = 4'd4;
    localparam logic [3:0] CLS_ORI  = 4'd5;
    localparam logic [3:0] CLS_LW   = 4'd6;
    localparam logic [3:0] CLS_SW   = 4'd7;
    localparam logic [3:0] CLS_BEQ  = 4'd8;
    localparam logic [3:0] CLS_JAL  = 4'd9;
    localparam logic [3:0] CLS_JALR = 4'd10;

    // Major opcodes
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STR  = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cls, w_cls_nxt;
    logic [4:0]        r_rd, w_rd_nxt;
    logic [4:0]        r_rs1, w_rs1_nxt;
    logic [4:0]        r_rs2, w_rs2_nxt;
    logic [20:0]       r_imm, w_imm_nxt;
    logic              r_in_ready, w_in_ready_nxt;
    logic              r_im_we, w_im_we_nxt;
    logic [ADDR_W-1:0] r_im_addr, w_im_addr_nxt;
    logic [31:0]       r_im_wdata, w_im_wdata_nxt;
    logic              r_err, w_err_nxt;
    logic [7:0]        r_err_cnt, w_err_cnt_nxt;
    logic              r_wrapped, w_wrapped_nxt;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_fit12;
    logic              w_fit13;

    // Immediate range checks: upper bits must be pure sign extension
    assign w_fit12 = (r_imm[20:11] == {10{r_imm[11]}});
    assign w_fit13 = (r_imm[20:12] == {9{r_imm[12]}});

    // Build the instruction word and its legality from the latched request
    always_comb begin
        w_word  = '0;
        w_legal = 1'b0;
        case (r_cls)
            CLS_ADD: begin
                w_word  = {F7_BASE, r_rs2, r_rs1, F3_ADD, r_rd, OP_R};
                w_legal = 1'b1;
            end
            CLS_SUB: begin
                w_word  = {F7_ALT, r_rs2, r_rs1, F3_ADD, r_rd, OP_R};
                w_legal = 1'b1;
            end
            CLS_OR: begin
                w_word  = {F7_BASE, r_rs2, r_rs1, F3_OR, r_rd, OP_R};
                w_legal = 1'b1;
            end
            CLS_AND: begin
                w_word  = {F7_BASE, r_rs2, r_rs1, F3_AND, r_rd, OP_R};
                w_legal = 1'b1;
            end
            CLS_ADDI: begin
                w_word  = {r_imm[11:0], r_rs1, F3_ADD, r_rd, OP_IMM};
                w_legal = w_fit12;
            end
            CLS_ORI: begin
                w_word  = {r_imm[11:0], r_rs1, F3_OR, r_rd, OP_IMM};
                w_legal = w_fit12;
            end
            CLS_LW: begin
                w_word  = {r_imm[11:0], r_rs1, F3_W, r_rd, OP_LOAD};
                w_legal = w_fit12;
            end
            CLS_SW: begin
                w_word  = {r_imm[11:5], r_rs2, r_rs1, F3_W, r_imm[4:0], OP_STR};
                w_legal = w_fit12;
            end
            CLS_BEQ: begin
                w_word  = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, F3_BEQ,
                           r_imm[4:1], r_imm[11], OP_BR};
                w_legal = w_fit13 & ~r_imm[0];
            end
            CLS_JAL: begin
                w_word  = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12],
                           r_rd, OP_JAL};
                w_legal = ~r_imm[0];
            end
            CLS_JALR: begin
                w_word  = {r_imm[11:0], r_rs1, F3_ADD, r_rd, OP_JALR};
                w_legal = w_fit12;
            end
            default: begin
                w_word  = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cls_nxt      = r_cls;
        w_rd_nxt       = r_rd;
        w_rs1_nxt      = r_rs1;
        w_rs2_nxt      = r_rs2;
        w_imm_nxt      = r_imm;
        w_in_ready_nxt = r_in_ready;
        w_im_we_nxt    = r_im_we;
        w_im_addr_nxt  = r_im_addr;
        w_im_wdata_nxt = r_im_wdata;
        w_err_nxt      = 1'b0;
        w_err_cnt_nxt  = r_err_cnt;
        w_wrapped_nxt  = r_wrapped;

        case (r_state)
            S_IDLE: begin
                w_in_ready_nxt = 1'b1;
                w_im_we_nxt    = 1'b0;
                if (clr) begin
                    // clr wins over a same-cycle request, which is dropped
                    w_im_addr_nxt = BASE_ADDR;
                    w_wrapped_nxt = 1'b0;
                    w_err_cnt_nxt = 8'd0;
                end else if (in_valid) begin
                    w_cls_nxt      = in_cls;
                    w_rd_nxt       = in_rd;
                    w_rs1_nxt      = in_rs1;
                    w_rs2_nxt      = in_rs2;
                    w_imm_nxt      = in_imm;
                    w_in_ready_nxt = 1'b0;
                    w_state_nxt    = S_ENC;
                end
            end
            S_ENC: begin
                if (w_legal) begin
                    w_im_wdata_nxt = w_word;
                    w_im_we_nxt    = 1'b1;
                    w_state_nxt    = S_WRITE;
                end else begin
                    w_err_nxt      = 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        w_err_cnt_nxt = r_err_cnt + 8'd1;
                    end
                    w_in_ready_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
            end
            S_WRITE: begin
                if (im_ack) begin
                    w_im_we_nxt    = 1'b0;
                    w_im_addr_nxt  = r_im_addr + ADDR_W'(1);
                    if (&r_im_addr) begin
                        w_wrapped_nxt = 1'b1;
                    end
                    w_in_ready_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_im_we_nxt    = 1'b0;
                w_in_ready_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cls      <= 4'd0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_imm      <= 21'd0;
            r_in_ready <= 1'b1;
            r_im_we    <= 1'b0;
            r_im_addr  <= BASE_ADDR;
            r_im_wdata <= 32'd0;
            r_err      <= 1'b0;
            r_err_cnt  <= 8'd0;
            r_wrapped  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cls      <= w_cls_nxt;
            r_rd       <= w_rd_nxt;
            r_rs1      <= w_rs1_nxt;
            r_rs2      <= w_rs2_nxt;
            r_imm      <= w_imm_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_im_we    <= w_im_we_nxt;
            r_im_addr  <= w_im_addr_nxt;
            r_im_wdata <= w_im_wdata_nxt;
            r_err      <= w_err_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_wrapped  <= w_wrapped_nxt;
        end
    end

    assign in_ready = r_in_ready;
    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;
    assign wrapped  = r_wrapped;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (8-bit and 2-bit address) share all
// inputs; a transaction-level model is checked against both every cycle.
module tb_instr_encoder;

    logic        clk;
    logic        rstn;
    logic        clr;
    logic        in_valid;
    logic [3:0]  in_cls;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [20:0] in_imm;
    logic        im_ack;

    logic        rdy_a, we_a, err_a, wrap_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [7:0]  ecnt_a;

    logic        rdy_b, we_b, err_b, wrap_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [7:0]  ecnt_b;

    instr_encoder #(.ADDR_W(8), .BASE(0)) dut_a (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy_a),
        .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .im_we(we_a), .im_addr(addr_a), .im_wdata(wdata_a), .im_ack(im_ack),
        .err(err_a), .err_cnt(ecnt_a), .wrapped(wrap_a)
    );

    instr_encoder #(.ADDR_W(2), .BASE(0)) dut_b (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy_b),
        .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .im_we(we_b), .im_addr(addr_b), .im_wdata(wdata_b), .im_ack(im_ack),
        .err(err_b), .err_cnt(ecnt_b), .wrapped(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: writes completed since reset/clr, rejected count, etc.
    int          m_cnt;
    int          m_err;
    logic        m_err_pulse;
    logic        m_we;
    logic        m_rdy;
    logic [31:0] m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level encoder: field placement by arithmetic shifts
    function automatic logic [31:0] ref_enc(input int cls, input int rd, input int rs1,
                                            input int rs2, input int imm);
        int w;
        int rfields;
        rfields = (rs2 << 20) | (rs1 << 15) | (rd << 7);
        case (cls)
            0:  w = rfields | 'h33;
            1:  w = (32 << 25) | rfields | 'h33;
            2:  w = rfields | (6 << 12) | 'h33;
            3:  w = rfields | (7 << 12) | 'h33;
            4:  w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h13;
            5:  w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (6 << 12) | (rd << 7) | 'h13;
            6:  w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
            7:  w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                    | ((imm & 'h1F) << 7) | 'h23;
            8:  w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
            9:  w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
            10: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
            default: w = 0;
        endcase
        return 32'(w);
    endfunction

    function automatic logic ref_legal(input int cls, input int imm);
        case (cls)
            0, 1, 2, 3:        return 1'b1;
            4, 5, 6, 7, 10:    return (imm >= -2048) && (imm <= 2047);
            8:                 return (imm >= -4096) && (imm <= 4095) && ((imm & 1) == 0);
            9:                 return (imm & 1) == 0;
            default:           return 1'b0;
        endcase
    endfunction

    // Per-cycle compare of both instances against the model
    task automatic check_cycle();
        int ecap;
        ecap = (m_err > 255) ? 255 : m_err;
        chk("in_ready_a", 32'(rdy_a), 32'(m_rdy));
        chk("in_ready_b", 32'(rdy_b), 32'(m_rdy));
        chk("im_we_a", 32'(we_a), 32'(m_we));
        chk("im_we_b", 32'(we_b), 32'(m_we));
        chk("im_wdata_a", wdata_a, m_word);
        chk("im_wdata_b", wdata_b, m_word);
        chk("im_addr_a", 32'(addr_a), 32'(m_cnt % 256));
        chk("im_addr_b", 32'(addr_b), 32'(m_cnt % 4));
        chk("wrapped_a", 32'(wrap_a), 32'(m_cnt >= 256));
        chk("wrapped_b", 32'(wrap_b), 32'(m_cnt >= 4));
        chk("err_a", 32'(err_a), 32'(m_err_pulse));
        chk("err_b", 32'(err_b), 32'(m_err_pulse));
        chk("err_cnt_a", 32'(ecnt_a), 32'(ecap));
        chk("err_cnt_b", 32'(ecnt_b), 32'(ecap));
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic model_reset();
        m_cnt       = 0;
        m_err       = 0;
        m_err_pulse = 1'b0;
        m_we        = 1'b0;
        m_rdy       = 1'b1;
        m_word      = 32'd0;
    endtask

    // One request: accept, encode, then write with ack after 'hold' stalled cycles
    task automatic send(input int cls, input int rd, input int rs1, input int rs2,
                        input int imm, input int hold, input logic [31:0] lit,
                        input string name);
        logic        legal;
        logic [31:0] word;
        legal = ref_legal(cls, imm);
        word  = ref_enc(cls, rd, rs1, rs2, imm);
        in_valid = 1'b1;
        in_cls   = 4'(cls);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = 21'(imm);
        m_rdy    = 1'b0;
        tick();
        // Scramble inputs: the encoder must use the latched copy
        in_valid = 1'b0;
        in_rd    = ~in_rd;
        in_rs1   = ~in_rs1;
        in_rs2   = ~in_rs2;
        in_imm   = ~in_imm;
        im_ack   = (hold == 0);
        if (legal) begin
            m_we   = 1'b1;
            m_word = word;
        end else begin
            m_err++;
            m_err_pulse = 1'b1;
            m_rdy       = 1'b1;
        end
        tick();
        m_err_pulse = 1'b0;
        if (legal) begin
            chk(name, wdata_a, lit);
            for (int k = 0; k < hold; k++) begin
                in_valid = 1'b1;
                in_cls   = 4'd0;
                tick();
            end
            in_valid = 1'b0;
            im_ack   = 1'b1;
            m_we     = 1'b0;
            m_cnt++;
            m_rdy    = 1'b1;
            tick();
        end
        im_ack = 1'b1;
    endtask

    initial begin
        rstn     = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_cls   = 4'd0;
        in_rd    = 5'd0;
        in_rs1   = 5'd0;
        in_rs2   = 5'd0;
        in_imm   = 21'd0;
        im_ack   = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Reset values
        chk("rst_in_ready", 32'(rdy_a), 32'd1);
        chk("rst_im_we", 32'(we_a), 32'd0);
        chk("rst_im_addr", 32'(addr_a), 32'd0);
        chk("rst_im_wdata", wdata_a, 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_err_cnt", 32'(ecnt_a), 32'd0);
        chk("rst_wrapped", 32'(wrap_a), 32'd0);
        tick();

        // Basic encodings with ack tied high
        send(0, 3, 1, 2, 0, 0, 32'h002081B3, "add");
        chk("add_addr_after", 32'(addr_a), 32'd1);
        send(4, 5, 0, 0, -1, 0, 32'hFFF00293, "addi_m1");
        send(7, 0, 1, 2, 8, 0, 32'h0020A423, "sw_8");
        send(8, 0, 1, 2, -4, 0, 32'hFE208EE3, "beq_m4");
        send(9, 1, 0, 0, 8, 0, 32'h008000EF, "jal_8");
        send(1, 1, 2, 3, 0, 0, 32'h403100B3, "sub");
        send(2, 4, 5, 6, 0, 0, 32'h0062E233, "or");
        send(3, 7, 8, 9, 0, 0, 32'h009473B3, "and");
        send(5, 10, 11, 0, 2047, 0, 32'h7FF5E513, "ori_max");
        send(6, 12, 13, 0, -2048, 0, 32'h8006A603, "lw_min");
        send(10, 1, 5, 0, 4, 0, 32'h004280E7, "jalr_4");
        send(9, 1, 0, 0, -8, 0, 32'hFF9FF0EF, "jal_m8");
        send(8, 0, 0, 0, 4094, 0, 32'h7E000FE3, "beq_max");
        chk("addr_after_13", 32'(addr_a), 32'd13);

        // Illegal requests
        send(4, 1, 1, 0, 2048, 0, 32'd0, "addi_2048");
        send(8, 0, 1, 2, 5, 0, 32'd0, "beq_odd");
        send(12, 1, 1, 1, 0, 0, 32'd0, "cls_12");
        chk("err_cnt_3", 32'(ecnt_a), 32'd3);
        chk("addr_unchanged", 32'(addr_a), 32'd13);
        chk("wdata_unchanged", wdata_a, 32'h7E000FE3);
        send(9, 1, 0, 0, 7, 0, 32'd0, "jal_odd");
        send(8, 0, 1, 2, 4096, 0, 32'd0, "beq_4096");
        send(7, 0, 1, 2, -2049, 0, 32'd0, "sw_m2049");

        // Stalled write: ack held low for 5 cycles
        send(2, 4, 5, 6, 0, 5, 32'h0062E233, "or_hold");
        chk("addr_after_hold", 32'(addr_a), 32'd14);

        // clr beats a same-cycle request
        clr      = 1'b1;
        in_valid = 1'b1;
        in_cls   = 4'd0;
        m_cnt    = 0;
        m_err    = 0;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_addr", 32'(addr_a), 32'd0);
        chk("clr_wrapped_b", 32'(wrap_b), 32'd0);
        chk("clr_err_cnt", 32'(ecnt_a), 32'd0);
        tick();

        // Five writes on the 2-bit instance wrap the address
        for (int i = 0; i < 5; i++) begin
            send(4, 1, 0, 0, 1, 0, 32'h00100093, "addi_wrap");
        end
        chk("wrap_addr_b", 32'(addr_b), 32'd1);
        chk("wrap_flag_b", 32'(wrap_b), 32'd1);
        chk("wrap_addr_a", 32'(addr_a), 32'd5);

        // err_cnt saturation
        for (int i = 0; i < 260; i++) begin
            send(15, 0, 0, 0, 0, 0, 32'd0, "illegal_sat");
        end
        chk("err_cnt_sat", 32'(ecnt_a), 32'd255);

        // Reset in the middle of a stalled write
        in_valid = 1'b1;
        in_cls   = 4'd0;
        in_rd    = 5'd3;
        in_rs1   = 5'd1;
        in_rs2   = 5'd2;
        m_rdy    = 1'b0;
        tick();
        in_valid = 1'b0;
        im_ack   = 1'b0;
        m_we     = 1'b1;
        m_word   = 32'h002081B3;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_we_a", 32'(we_a), 32'd0);
        chk("rst_mid_we_b", 32'(we_b), 32'd0);
        chk("rst_mid_ready", 32'(rdy_a), 32'd1);
        chk("rst_mid_addr", 32'(addr_a), 32'd0);
        model_reset();
        tick();
        rstn   = 1'b1;
        im_ack = 1'b1;
        tick();
        send(0, 3, 1, 2, 0, 0, 32'h002081B3, "add_post_rst");
        chk("post_rst_addr", 32'(addr_a), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the CPU's instruction decoder/control unit.
- Accepts symbolic instruction requests (class + register fields + immediate) over a valid/ready handshake and packs them into 32-bit RV32I words.
- Writes each word into instruction memory at consecutive word addresses using a write/ack handshake.
- Used by the boot/test loader to build programs for the single-cycle core; covers the same instruction subset the core decodes.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE, 0, word address written after reset or clr.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous pulse: im_addr<=BASE, wrapped<=0, err_cnt<=0; ignored unless state is IDLE.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_cls  in  4  class: 0 add, 1 sub, 2 or, 3 and, 4 addi, 5 ori, 6 lw, 7 sw, 8 beq, 9 jal, 10 jalr, 11-15 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  21  signed immediate (byte offset for beq/jal).
- im_we  out  1  instruction-memory write request.
- im_addr  out  ADDR_W  word address of the current/next write.
- im_wdata  out  32  encoded instruction.
- im_ack  in  1  memory accepted the write.
- err  out  1  one-cycle pulse: request rejected.
- err_cnt  out  8  rejected-request count, saturates at 255.
- wrapped  out  1  sticky: im_addr has wrapped past all-ones.

Behaviour:
- Reset values: state=IDLE, in_ready=1, im_we=0, im_addr=BASE, im_wdata=0, err=0, err_cnt=0, wrapped=0.
- FSM states: IDLE, ENC, WRITE.
- IDLE:
  - in_ready=1.
  - in_valid=1 latches all fields; next state ENC.
  - clr in IDLE takes priority over accepting a request in the same cycle; that request is not taken.
- ENC:
  - in_ready=0.
  - Builds the word combinationally from the latched fields and checks it.
  - Legal request: register the word into im_wdata; next state WRITE.
  - Illegal request: pulse err, increment err_cnt (saturating), leave im_addr and im_wdata unchanged, return to IDLE.
- WRITE:
  - in_ready=0; im_we=1; im_wdata and im_addr held stable.
  - On im_ack=1: im_we deasserts the next cycle and im_addr increments by 1 (modulo 2^ADDR_W).
  - Increment from all-ones to 0 sets wrapped.
  - Next state IDLE.
  - im_ack may stay low indefinitely; im_ack outside WRITE is ignored.
- Throughput: one instruction per at least 3 cycles (accept, encode, write with ack the same cycle).
- Encodings, bit 31 down to bit 0:
  - R-type: funct7|rs2|rs1|funct3|rd|0110011.
    - add: funct7 0000000, funct3 000.
    - sub: funct7 0100000, funct3 000.
    - or: funct7 0000000, funct3 110.
    - and: funct7 0000000, funct3 111.
  - I-type: imm[11:0]|rs1|funct3|rd|opcode.
    - addi: opcode 0010011, funct3 000.
    - ori: opcode 0010011, funct3 110.
    - lw: opcode 0000011, funct3 010.
    - jalr: opcode 1100111, funct3 000.
  - S-type (sw): imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - B-type (beq): imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
  - J-type (jal): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - Fields not used by a class are ignored.
- Legality rules; any failure rejects the request:
  - in_cls of 11-15 is illegal.
  - I- and S-types: in_imm[20:11] must be all equal (fits signed 12-bit).
  - beq: in_imm[20:12] must be all equal and in_imm[0]=0.
  - jal: in_imm[0] must be 0; the full 21 bits are used.
- Reset mid-write: im_we drops immediately; the partially acknowledged word is lost; state returns to IDLE.

Test Plan:
- add, rd=3, rs1=1, rs2=2 with im_ack tied high -> im_wdata=0x002081B3 at im_addr 0; im_addr becomes 1; exactly one im_we cycle.
- addi, rd=5, rs1=0, imm=-1 -> 0xFFF00293. sw, rs1=1, rs2=2, imm=8 -> 0x0020A423. Written at consecutive addresses.
- beq, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. jal, rd=1, imm=8 -> 0x008000EF.
- Illegal requests: addi imm=2048; beq imm=6 with odd low bit set is not the case, so use beq imm=5 (odd); in_cls=12 -> three err pulses, err_cnt=3, no im_we, im_addr unchanged.
- Hold im_ack low 5 cycles in WRITE -> im_we, im_addr and im_wdata stable; in_ready=0 and in_valid is ignored; ack -> im_addr increments once.
- ADDR_W=2, five legal writes -> im_addr sequence 0,1,2,3,0 and wrapped=1; clr in IDLE -> im_addr=0, wrapped=0, err_cnt=0. Assert rstn low during WRITE -> im_we=0 asynchronously.
